wb_sram: RTL

WB_SRAM -- requirements
Module: wb_sram

---
 rtl/wb_sram.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/wb_sram.sv
`default_nettype none
// ============================================================================
// Module   : wb_sram
// Purpose  : Wishbone (pipelined mode) single-port SRAM slave with a
//            configurable, fixed response latency and optional periodic
//            stall injection.
//
// Parameters
//   DEPTH_WORDS  : number of 32-bit words (1..65536)
//   LATENCY      : cycles from request acceptance to response (1..4)
//   STALL_PERIOD : stall every STALL_PERIOD cycles; 0 disables (0, 2..255)
//
// Ports
//   clk_i      in   1  clock, rising edge
//   reset_ni   in   1  asynchronous active-low reset
//   wb_cyc_i   in   1  bus cycle valid
//   wb_stb_i   in   1  request strobe
//   wb_we_i    in   1  1 = write, 0 = read
//   wb_addr_i  in  30  word address
//   wb_sel_i   in   4  byte enables (write only)
//   wb_data_i  in  32  write data
//   wb_ack_o   out  1  successful response
//   wb_err_o   out  1  error response (address out of range)
//   wb_stall_o out  1  request not accepted this cycle
//   wb_data_o  out 32  read data, zero except on a read ack
//
// Revision : 1.0 - initial release
// ============================================================================
module wb_sram #(
    parameter int DEPTH_WORDS  = 1024,
    parameter int LATENCY      = 1,
    parameter int STALL_PERIOD = 0
) (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [29:0] wb_addr_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [31:0] wb_data_i,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic        wb_stall_o,
    output logic [31:0] wb_data_o
);

    // Index width into the storage array; a single-word memory still
    // needs a one-bit index.
    localparam int          c_IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    // Depth widened by one bit so the full 30-bit address compares cleanly.
    localparam logic [30:0] c_DEPTH = 31'(DEPTH_WORDS);

    logic               w_stall;
    logic               w_accept;
    logic               w_in_range;
    logic               w_wr_en;
    logic [c_IDX_W-1:0] w_idx;
    logic [31:0]        w_rd_word;
    logic [31:0]        w_rd_data;

    // Storage powers up cleared and is deliberately outside the reset
    // domain: reset must never wipe memory contents.
    logic [31:0] r_mem [DEPTH_WORDS] = '{default: '0};

    // Response pipeline: stage 0 is loaded at the accepting edge, the last
    // stage drives the bus, so a response appears LATENCY cycles later.
    logic        r_ack_pipe  [LATENCY];
    logic        r_err_pipe  [LATENCY];
    logic [31:0] r_data_pipe [LATENCY];

    // ------------------------------------------------------------------------
    // Stall injection. The stall output is a pure function of a free-running
    // counter, so it never depends on any bus input.
    // ------------------------------------------------------------------------
    generate
        if (STALL_PERIOD == 0) begin : g_no_stall
            assign w_stall = 1'b0;
        end else begin : g_stall
            localparam logic [7:0] c_LAST = 8'(STALL_PERIOD - 1);

            logic [7:0] r_stall_cnt;

            always_ff @(posedge clk_i or negedge reset_ni) begin
                if (!reset_ni) begin
                    r_stall_cnt <= 8'd0;
                end else if (r_stall_cnt == c_LAST) begin
                    r_stall_cnt <= 8'd0;
                end else begin
                    r_stall_cnt <= r_stall_cnt + 8'd1;
                end
            end

            // The counter sits at zero during reset and c_LAST is never zero
            // for a legal period, so stall is low while in reset.
            assign w_stall = (r_stall_cnt == c_LAST);
        end
    endgenerate

    assign wb_stall_o = w_stall;

    // ------------------------------------------------------------------------
    // Request decode. Qualifying with reset_ni keeps a request presented
    // during reset from writing memory.
    // ------------------------------------------------------------------------
    assign w_accept   = reset_ni && wb_cyc_i && wb_stb_i && !w_stall;
    assign w_in_range = ({1'b0, wb_addr_i} < c_DEPTH);
    assign w_idx      = wb_addr_i[c_IDX_W-1:0];
    assign w_wr_en    = w_accept && w_in_range && wb_we_i;

    // Only one request is accepted per cycle, so a read never races a write
    // in the same cycle; reading the array at the accepting edge returns any
    // write committed at an earlier edge.
    assign w_rd_word  = r_mem[w_idx];
    assign w_rd_data  = (w_accept && w_in_range && !wb_we_i) ? w_rd_word : 32'd0;

    // ------------------------------------------------------------------------
    // Memory write with per-byte enables. wb_sel_i = 0 is a legal no-op
    // write that still earns an ack.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (w_wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wb_sel_i[b]) begin
                    r_mem[w_idx][8*b +: 8] <= wb_data_i[8*b +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Response pipeline. Dropping wb_cyc_i flushes every in-flight response;
    // writes already committed to the array are unaffected.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            for (int s = 0; s < LATENCY; s++) begin
                r_ack_pipe[s]  <= 1'b0;
                r_err_pipe[s]  <= 1'b0;
                r_data_pipe[s] <= 32'd0;
            end
        end else if (!wb_cyc_i) begin
            for (int s = 0; s < LATENCY; s++) begin
                r_ack_pipe[s]  <= 1'b0;
                r_err_pipe[s]  <= 1'b0;
                r_data_pipe[s] <= 32'd0;
            end
        end else begin
            r_ack_pipe[0]  <= w_accept && w_in_range;
            r_err_pipe[0]  <= w_accept && !w_in_range;
            r_data_pipe[0] <= w_rd_data;
            for (int s = 1; s < LATENCY; s++) begin
                r_ack_pipe[s]  <= r_ack_pipe[s-1];
                r_err_pipe[s]  <= r_err_pipe[s-1];
                r_data_pipe[s] <= r_data_pipe[s-1];
            end
        end
    end

    // Gating with wb_cyc_i also hides a response that is already at the
    // output in the very cycle the master abandons the bus cycle.
    assign wb_ack_o  = r_ack_pipe[LATENCY-1] && wb_cyc_i;
    assign wb_err_o  = r_err_pipe[LATENCY-1] && wb_cyc_i;
    assign wb_data_o = wb_cyc_i ? r_data_pipe[LATENCY-1] : 32'd0;

endmodule
`default_nettype wire
